// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the branch resolution queue.
//   brq_entry_t   - one in-flight predicted branch captured at fetch.
//   BRQ_RUN/FLUSH - queue control FSM encodings.
//   brq_redirect  - correct-path PC for a resolved entry.
package rv32i_types;

    typedef struct packed {
        logic [31:0] pc;
        logic        global_pred;
        logic        local_pred;
        logic        prediction;
        logic        is_jal;
    } brq_entry_t;

    localparam logic [0:0] BRQ_RUN   = 1'b0;
    localparam logic [0:0] BRQ_FLUSH = 1'b1;

    // Taken branches go to the resolved target, not-taken ones fall through.
    function automatic logic [31:0] brq_redirect(input brq_entry_t  entry,
                                                 input logic        taken,
                                                 input logic [31:0] target);
        return taken ? target : entry.pc + 32'd4;
    endfunction

endpackage

// File: rtl/brq_fifo.sv
// brq_fifo: in-order storage for predicted branches awaiting resolution.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pointers/count only)
//   push        - write push_data at the tail (ignored when full)
//   push_data   - entry to write
//   pop         - retire the head entry (ignored when empty)
//   clear       - drop every entry; wins over a same-cycle push/pop
//   full, empty - occupancy flags
//   count       - number of valid entries, 0..DEPTH
//   head        - oldest entry (undefined when empty)
module brq_fifo
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  brq_entry_t               push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output brq_entry_t               head
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

    brq_entry_t        entries [DEPTH];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        full    = (count == FullCount);
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = entries[rd_ptr];
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; a write under clear is harmless since the pointers restart.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/branch_resolution_queue.sv
// branch_resolution_queue: tracks predicted branches from IF until they resolve
// in MEM, produces the predictor training bundle and the mispredict redirect.
// Optional feature: define BRQ_STATS_EN to add branch/mispredict statistics.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   if_valid / if_ready            - push handshake from IF (ready low stalls IF)
//   if_pc, if_*_pred, if_prediction, if_is_jal - entry captured at fetch
//   mem_resolve, mem_taken, mem_target - resolution of the oldest entry
//   MEM_global_prediction, MEM_local_prediction, branch_result - training data
//   update                         - one-cycle pulse: train predictor (non-jal)
//   mispredict, redirect_pc        - one-cycle redirect pulse and target
//   underflow_err                  - sticky: resolve seen with an empty queue
//   stat_branches, stat_mispredicts - (BRQ_STATS_EN only) wrapping counters
module branch_resolution_queue
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic        if_global_pred,
    input  logic        if_local_pred,
    input  logic        if_prediction,
    input  logic        if_is_jal,
    input  logic        mem_resolve,
    input  logic        mem_taken,
    input  logic [31:0] mem_target,
    output logic        MEM_global_prediction,
    output logic        MEM_local_prediction,
    output logic        branch_result,
    output logic        update,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        underflow_err
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    logic [0:0]             state_q;
    logic [0:0]             state_d;
    brq_entry_t             push_data;
    brq_entry_t             head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   push;
    logic                   pop;
    logic                   resolve_ok;
    logic                   underflow_hit;
    logic                   update_d;
    logic                   mispredict_d;

    always_comb begin
        push_data.pc          = if_pc;
        push_data.global_pred = if_global_pred;
        push_data.local_pred  = if_local_pred;
        push_data.prediction  = if_prediction;
        push_data.is_jal      = if_is_jal;

        // No full-queue bypass; rst_n gating keeps IF stalled throughout reset.
        if_ready      = rst_n && !fifo_full && (state_q == BRQ_RUN);
        push          = if_valid && if_ready;
        // Resolves arriving during the flush bubble belong to squashed work.
        resolve_ok    = mem_resolve && (state_q == BRQ_RUN);
        pop           = resolve_ok && !fifo_empty;
        underflow_hit = resolve_ok && (fifo_count == '0);
        update_d      = pop && !head.is_jal;
        mispredict_d  = update_d && (head.prediction != mem_taken);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BRQ_RUN:   if (mispredict_d) state_d = BRQ_FLUSH;
            BRQ_FLUSH: state_d = BRQ_RUN;
            default:   state_d = BRQ_RUN;
        endcase
    end

    // A mispredict squashes every younger entry, including one pushed this cycle.
    brq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (mispredict_d),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q               <= BRQ_RUN;
            MEM_global_prediction <= 1'b0;
            MEM_local_prediction  <= 1'b0;
            branch_result         <= 1'b0;
            update                <= 1'b0;
            mispredict            <= 1'b0;
            redirect_pc           <= 32'd0;
            underflow_err         <= 1'b0;
        end else begin
            state_q    <= state_d;
            update     <= update_d;
            mispredict <= mispredict_d;
            if (pop) begin
                MEM_global_prediction <= head.global_pred;
                MEM_local_prediction  <= head.local_pred;
                branch_result         <= mem_taken;
                redirect_pc           <= brq_redirect(head, mem_taken, mem_target);
            end
            if (underflow_hit) begin
                underflow_err <= 1'b1;
            end
        end
    end

`ifdef BRQ_STATS_EN
    // Counted on the same edge that raises the corresponding pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (update_d) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict_d) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/branch_resolution_queue.md
BRANCH_RESOLUTION_QUEUE -- requirements
Module: branch_resolution_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of in-flight predicted-branch entries; power of two, 2..16.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 if_valid  in  1  a predicted branch or jal is leaving IF this cycle.
REQ-005 if_ready  out  1  queue can accept a push this cycle; IF stalls when low.
REQ-006 if_pc  in  32  fetch PC of the branch.
REQ-007 if_global_pred, if_local_pred, if_prediction, if_is_jal  in  1 each  predictor outputs captured at fetch.
REQ-008 mem_resolve  in  1  oldest in-flight branch is resolved in MEM this cycle.
REQ-009 mem_taken  in  1  actual branch outcome.
REQ-010 mem_target  in  32  actual taken target.
REQ-011 MEM_global_prediction, MEM_local_prediction, branch_result, update  out  1 each  predictor training bundle.
REQ-012 mispredict  out  1  redirect pulse.
REQ-013 redirect_pc  out  32  mem_target when taken, else entry pc+4.
REQ-014 underflow_err  out  1  sticky error flag.

Function
REQ-015 The block SHALL be a FIFO of DEPTH entries {pc, global_pred, local_pred, prediction, is_jal}, written in fetch order.
REQ-016 if_ready SHALL equal (count != DEPTH) and (state == RUN); no full-queue bypass, so a push is refused when full even if a pop occurs in the same cycle.
REQ-017 A push SHALL occur on an edge where if_valid and if_ready are both high.
REQ-018 A pop SHALL occur on an edge where mem_resolve is high and count != 0.
REQ-019 Simultaneous push and pop SHALL leave count unchanged.
REQ-020 Pointers SHALL wrap modulo DEPTH.
REQ-021 mem_resolve with count == 0 SHALL set underflow_err until reset and SHALL produce no pulse; a push in the same cycle still completes.
REQ-022 On a pop, the next edge SHALL register MEM_global_prediction, MEM_local_prediction and branch_result = mem_taken from the head entry (latency 1 cycle).
REQ-023 update SHALL pulse one cycle for a popped entry with is_jal == 0.
REQ-024 mispredict SHALL pulse one cycle when the popped entry's prediction != mem_taken; a jal entry never mispredicts.
REQ-025 FSM states: RUN and FLUSH.
REQ-026 RUN -> FLUSH on the edge registering mispredict; that edge SHALL clear count and both pointers, discarding any same-cycle push.
REQ-027 FLUSH SHALL last exactly one cycle with if_ready = 0, mem_resolve ignored, then return to RUN.
REQ-028 Outputs not updated on an edge SHALL hold, except update and mispredict, which SHALL return to 0.

Reset
REQ-029 rst_n low SHALL immediately force state = RUN, count = 0, pointers = 0, and all outputs to 0, including redirect_pc and underflow_err.
REQ-030 While rst_n is low, if_ready SHALL be 0.
REQ-031 Reset during FLUSH or with entries queued SHALL discard all entries.
REQ-032 Entry storage contents need not be reset.

Configuration
REQ-033 With BRQ_STATS_EN defined, the block SHALL add outputs stat_branches[31:0] and stat_mispredicts[31:0]:
- stat_branches increments on each update pulse.
- stat_mispredicts increments on each mispredict pulse.
- Both counters wrap at 2^32 and reset to 0.
REQ-034 Without BRQ_STATS_EN, those ports and counters SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-035 The entry struct brq_entry_t SHALL be defined in package rv32i_types.
REQ-036 FIFO storage and pointers SHALL be a sub-module brq_fifo (parameter DEPTH; push, pop, clear, full, empty, count, head); the FSM and output registers sit in the top module.

Verification
REQ-037 Push 4 entries, pc 0x100..0x10C, preds 0 -> if_ready = 0 after 4th; a 5th if_valid is refused; count = 4.
REQ-038 Resolve the head (pc 0x100, prediction 1, global 1, local 0) with mem_taken 1 -> next cycle update = 1, mispredict = 0, branch_result = 1, MEM_global_prediction = 1, MEM_local_prediction = 0.
REQ-039 Resolve entry pc 0x104, prediction 0, with mem_taken 1, mem_target 0x200 -> mispredict = 1, redirect_pc = 0x200, count = 0, if_ready = 0 for one cycle, then 1.
REQ-040 Resolve a jal entry (is_jal 1, prediction 1) with mem_taken 1 -> update = 0, mispredict = 0, count decremented.
REQ-041 mem_resolve on an empty queue with simultaneous if_valid -> underflow_err = 1 (sticky), count = 1, no pulses.
REQ-042 Deassert rst_n mid-FLUSH with 3 entries queued -> all outputs 0 at once; after release, if_ready = 1, count = 0; with BRQ_STATS_EN, counters = 0.
